mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 16, byte-address width on all ports.
REQ-002 Parameter: DATA_W, default 16, word width on all data ports.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset: i_clk  in  1  clock; i_reset  in  1  async active-high reset.
REQ-004 Per master N in {0,1}, the block SHALL provide: i_mN_addr in ADDR_W; i_mN_rd in 1; i_mN_wr in 1; i_mN_wrdata in DATA_W; i_mN_lock in 1 (lock request); o_mN_waitrequest out 1 (request not accepted this cycle); o_mN_rddata out DATA_W; o_mN_rdvalid out 1 (read data valid).
REQ-005 Memory side ports SHALL be: o_mem_addr out ADDR_W; o_mem_rd out 1; o_mem_wr out 1; o_mem_wrdata out DATA_W; i_mem_rddata in DATA_W (valid exactly 1 cycle after o_mem_rd).

Function
REQ-006 A request from master N is defined as i_mN_rd | i_mN_wr.
REQ-007 Exactly one master SHALL be granted per cycle; the granted master's addr/rd/wr/wrdata SHALL drive the memory port combinationally in the same cycle.
REQ-008 o_mN_waitrequest SHALL equal request_N & ~grant_N; a master SHALL hold its request stable until waitrequest is low.
REQ-009 If only one master requests, that master SHALL be granted.
REQ-010 If both masters request, the master not granted most recently SHALL be granted (round-robin); last_grant updates only on cycles with a grant.
REQ-011 If i_mN_rd and i_mN_wr are both high, the write SHALL be forwarded and the read suppressed (no rdvalid).
REQ-012 No request: o_mem_rd = o_mem_wr = 0; o_mem_addr/o_mem_wrdata are don't-care.
REQ-013 Read latency: a read granted in cycle T SHALL produce o_mN_rdvalid = 1 and o_mN_rddata = i_mem_rddata in cycle T+1 for that master only; the other master's rdvalid SHALL be 0.
REQ-014 Back-to-back reads (same or alternating masters) SHALL sustain one accepted read per cycle with correct per-master rdvalid routing.
REQ-015 o_mN_rddata SHALL be driven directly from i_mem_rddata; only rdvalid qualifies it.

Reset
REQ-016 While i_reset is high: o_mem_rd = o_mem_wr = 0, o_m0_waitrequest = o_m1_waitrequest = 1, o_m0_rdvalid = o_m1_rdvalid = 0.
REQ-017 Reset SHALL set last_grant = master 1 (master 0 wins the first conflict), clear the pending-read tag and clear lock state.
REQ-018 Reset asserted while a read is outstanding SHALL drop it: no rdvalid after reset deassertion.

Configuration
REQ-019 Macro MEM_ARB_LOCK_EN: when defined, the granted master N with i_mN_lock = 1 SHALL become lock owner from the next cycle; while locked, the other master SHALL be held in waitrequest even if the owner is idle; the lock SHALL release in the cycle after the owner samples i_mN_lock = 0.
REQ-020 When MEM_ARB_LOCK_EN is undefined, i_mN_lock SHALL be ignored and no lock state SHALL be synthesized; ports remain present.

Structure
REQ-021 Package mem_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the master-id typedef (M0, M1), and the lock state enum (UNLOCKED, LOCKED_M0, LOCKED_M1).
REQ-022 Round-robin grant computation SHALL be a sub-module mem_arb_rr (inputs: two requests, last_grant, lock mask; output: one-hot grant).
REQ-023 Registered state SHALL be limited to last_grant, pending-read valid + master tag, and lock state.

Verification
REQ-024 M0 read 0x0010 alone, mem[0x0008] = 0x1234 -> o_mem_rd in cycle T, o_m0_rdvalid = 1 with 0x1234 in T+1, o_m1_rdvalid = 0.
REQ-025 M0 and M1 both read continuously from reset -> grants alternate M0, M1, M0, M1; each waitrequest low every second cycle.
REQ-026 M1 write 0x1000 = 0x00AB while M0 idle -> o_mem_wr = 1, o_mem_addr = 0x1000, o_mem_wrdata = 0x00AB same cycle, o_m1_waitrequest = 0.
REQ-027 M0 rd and wr both high to 0x0020 with data 0x5555 -> only o_mem_wr = 1; no rdvalid next cycle.
REQ-028 Reset pulsed in the cycle after M1 read grant -> o_m1_rdvalid stays 0; after release, first conflict grants M0.
REQ-029 With MEM_ARB_LOCK_EN: M0 reads with lock = 1 for 3 cycles, then idles with lock = 1 for 2 cycles, while M1 requests throughout -> M1 waitrequest = 1 for those 5 cycles; M1 granted in the cycle after M0 drops lock.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter: default widths,
// master identifiers, lock state encoding and small decode helpers.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'b00,
    LOCKED_M0 = 2'b01,
    LOCKED_M1 = 2'b10
  } lock_state_e;

  // Masters allowed to compete for the memory in a given lock state.
  // Bit N set means master N may be granted.
  function automatic logic [1:0] lock_mask(input lock_state_e st);
    logic [1:0] mask;
    case (st)
      UNLOCKED:  mask = 2'b11;
      LOCKED_M0: mask = 2'b01;
      LOCKED_M1: mask = 2'b10;
      default:   mask = 2'b11;
    endcase
    return mask;
  endfunction

  // Identity of the master selected by a one-hot (or empty) grant vector.
  // An empty grant maps to M0; callers only use the result when a grant exists.
  function automatic master_id_e grant_to_id(input logic [1:0] grant);
    master_id_e id;
    if (grant[1]) begin
      id = M1;
    end else begin
      id = M0;
    end
    return id;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant for the memory arbiter. Requests are first
// filtered by the lock mask; on a conflict the master that did not win most
// recently is chosen. Purely combinational: the grant must steer the memory
// port in the same cycle the request is presented.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  master_id_e i_last_grant,
  input  logic [1:0] i_lock_mask,
  output logic [1:0] o_grant
);

  logic [1:0] elig_s;

  // Pick at most one eligible master, favouring the one not served last.
  always_comb begin
    elig_s  = i_req & i_lock_mask;
    o_grant = 2'b00;
    case (elig_s)
      2'b01: o_grant = 2'b01;
      2'b10: o_grant = 2'b10;
      2'b11: begin
        if (i_last_grant == M1) begin
          o_grant = 2'b01;
        end else begin
          o_grant = 2'b10;
        end
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, single-port memory arbiter with round-robin conflict
// resolution and one-cycle read return routing.
//
// Optional feature: define MEM_ARB_LOCK_EN to enable bus locking. A granted
// master holding i_mN_lock becomes lock owner from the next cycle and the
// other master is held off until the owner drops its lock. Without the macro
// the lock inputs are accepted but ignored and no lock state exists.
//
// The memory port is driven combinationally from the granted master so that
// an accepted request reaches memory in the cycle it is presented. The only
// state is the last winner, the outstanding-read tag and the lock owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,

  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic              i_m0_rd,
  input  logic              i_m0_wr,
  input  logic [DATA_W-1:0] i_m0_wrdata,
  input  logic              i_m0_lock,
  output logic              o_m0_waitrequest,
  output logic [DATA_W-1:0] o_m0_rddata,
  output logic              o_m0_rdvalid,

  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic              i_m1_rd,
  input  logic              i_m1_wr,
  input  logic [DATA_W-1:0] i_m1_wrdata,
  input  logic              i_m1_lock,
  output logic              o_m1_waitrequest,
  output logic [DATA_W-1:0] o_m1_rddata,
  output logic              o_m1_rdvalid,

  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wrdata,
  input  logic [DATA_W-1:0] i_mem_rddata
);

  logic [1:0]        req_s;
  logic [1:0]        lock_mask_s;
  logic [1:0]        rr_grant_s;
  logic [1:0]        grant_s;
  logic [1:0]        waitreq_s;

  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wrdata_s;
  logic              sel_rd_s;
  logic              sel_wr_s;
  logic              mem_rd_s;
  logic              mem_wr_s;

  master_id_e        last_grant_q;
  master_id_e        last_grant_d;
  logic              pend_valid_q;
  logic              pend_valid_d;
  master_id_e        pend_tag_q;
  master_id_e        pend_tag_d;

  assign req_s = {i_m1_rd | i_m1_wr, i_m0_rd | i_m0_wr};

`ifdef MEM_ARB_LOCK_EN
  lock_state_e lock_q;
  lock_state_e lock_d;

  // Lock owner tracking: acquire on a granted locked request, release one
  // cycle after the owner presents lock low (owner need not be requesting).
  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      UNLOCKED: begin
        if (grant_s[0] && i_m0_lock) begin
          lock_d = LOCKED_M0;
        end else if (grant_s[1] && i_m1_lock) begin
          lock_d = LOCKED_M1;
        end else begin
          lock_d = UNLOCKED;
        end
      end
      LOCKED_M0: begin
        if (!i_m0_lock) begin
          lock_d = UNLOCKED;
        end else begin
          lock_d = LOCKED_M0;
        end
      end
      LOCKED_M1: begin
        if (!i_m1_lock) begin
          lock_d = UNLOCKED;
        end else begin
          lock_d = LOCKED_M1;
        end
      end
      default: lock_d = UNLOCKED;
    endcase
  end

  // Lock state register; reset leaves the bus unlocked.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lock_q <= UNLOCKED;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign lock_mask_s = lock_mask(lock_q);
`else
  // Lock inputs stay on the interface but have no effect in this build.
  logic unused_lock_s;
  assign unused_lock_s = i_m0_lock ^ i_m1_lock;
  assign lock_mask_s   = 2'b11;
`endif

  mem_arb_rr u_rr (
    .i_req        (req_s),
    .i_last_grant (last_grant_q),
    .i_lock_mask  (lock_mask_s),
    .o_grant      (rr_grant_s)
  );

  // Reset forces every master to wait and keeps the memory port quiet,
  // independent of the clock.
  always_comb begin
    if (i_reset) begin
      grant_s   = 2'b00;
      waitreq_s = 2'b11;
    end else begin
      grant_s   = rr_grant_s;
      waitreq_s = req_s & ~rr_grant_s;
    end
  end

  // Steer the granted master onto the memory port; a combined read+write
  // is forwarded as a write only.
  always_comb begin
    if (grant_s[1]) begin
      sel_addr_s   = i_m1_addr;
      sel_wrdata_s = i_m1_wrdata;
      sel_rd_s     = i_m1_rd;
      sel_wr_s     = i_m1_wr;
    end else if (grant_s[0]) begin
      sel_addr_s   = i_m0_addr;
      sel_wrdata_s = i_m0_wrdata;
      sel_rd_s     = i_m0_rd;
      sel_wr_s     = i_m0_wr;
    end else begin
      sel_addr_s   = i_m0_addr;
      sel_wrdata_s = i_m0_wrdata;
      sel_rd_s     = 1'b0;
      sel_wr_s     = 1'b0;
    end
    mem_wr_s = sel_wr_s;
    mem_rd_s = sel_rd_s & ~sel_wr_s;
  end

  // Next-state for the round-robin pointer and the outstanding-read tag.
  always_comb begin
    if (grant_s[1]) begin
      last_grant_d = M1;
    end else if (grant_s[0]) begin
      last_grant_d = M0;
    end else begin
      last_grant_d = last_grant_q;
    end

    pend_valid_d = mem_rd_s;
    if (mem_rd_s) begin
      pend_tag_d = grant_to_id(grant_s);
    end else begin
      pend_tag_d = pend_tag_q;
    end
  end

  // Arbiter state; reset makes M0 win the first conflict and drops any
  // read still in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      last_grant_q <= M1;
      pend_valid_q <= 1'b0;
      pend_tag_q   <= M0;
    end else begin
      last_grant_q <= last_grant_d;
      pend_valid_q <= pend_valid_d;
      pend_tag_q   <= pend_tag_d;
    end
  end

  assign o_mem_addr   = sel_addr_s;
  assign o_mem_wrdata = sel_wrdata_s;
  assign o_mem_rd     = mem_rd_s;
  assign o_mem_wr     = mem_wr_s;

  assign o_m0_waitrequest = waitreq_s[0];
  assign o_m1_waitrequest = waitreq_s[1];

  // Read data is shared; rdvalid alone tells each master whether it is theirs.
  assign o_m0_rddata  = i_mem_rddata;
  assign o_m1_rddata  = i_mem_rddata;
  assign o_m0_rdvalid = pend_valid_q & (pend_tag_q == M0) & ~i_reset;
  assign o_m1_rdvalid = pend_valid_q & (pend_tag_q == M1) & ~i_reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          i_reset;
  logic [AW-1:0] i_m0_addr, i_m1_addr;
  logic          i_m0_rd, i_m0_wr, i_m0_lock;
  logic          i_m1_rd, i_m1_wr, i_m1_lock;
  logic [DW-1:0] i_m0_wrdata, i_m1_wrdata;
  logic          o_m0_waitrequest, o_m1_waitrequest;
  logic [DW-1:0] o_m0_rddata, o_m1_rddata;
  logic          o_m0_rdvalid, o_m1_rdvalid;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_rd, o_mem_wr;
  logic [DW-1:0] o_mem_wrdata;
  logic [DW-1:0] i_mem_rddata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_m0_addr        (i_m0_addr),
    .i_m0_rd          (i_m0_rd),
    .i_m0_wr          (i_m0_wr),
    .i_m0_wrdata      (i_m0_wrdata),
    .i_m0_lock        (i_m0_lock),
    .o_m0_waitrequest (o_m0_waitrequest),
    .o_m0_rddata      (o_m0_rddata),
    .o_m0_rdvalid     (o_m0_rdvalid),
    .i_m1_addr        (i_m1_addr),
    .i_m1_rd          (i_m1_rd),
    .i_m1_wr          (i_m1_wr),
    .i_m1_wrdata      (i_m1_wrdata),
    .i_m1_lock        (i_m1_lock),
    .o_m1_waitrequest (o_m1_waitrequest),
    .o_m1_rddata      (o_m1_rddata),
    .o_m1_rdvalid     (o_m1_rdvalid),
    .o_mem_addr       (o_mem_addr),
    .o_mem_rd         (o_mem_rd),
    .o_mem_wr         (o_mem_wr),
    .o_mem_wrdata     (o_mem_wrdata),
    .i_mem_rddata     (i_mem_rddata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory device: word-addressed by byte address, read data one cycle later.
  logic [DW-1:0] mem [0:32767];
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 7 + 3);
    mem[8] = 16'h1234;
    forever begin
      @(posedge clk);
      if (o_mem_wr) mem[o_mem_addr[15:1]] <= o_mem_wrdata;
      if (o_mem_rd) i_mem_rddata <= mem[o_mem_addr[15:1]];
    end
  end

  // Stimulus for the current cycle.
  logic          s_rst;
  logic          s_rd [2];
  logic          s_wr [2];
  logic          s_lk [2];
  logic [15:0]   s_addr [2];
  logic [15:0]   s_wd [2];
  bit            s_acc [2];

  // Reference model state.
  int            last_m;
  int            owner;
  bit            pv;
  int            pm;
  logic [15:0]   pd;
  logic [15:0]   ref_mem [0:32767];

  task automatic model_reset();
    last_m = 1;
    owner  = -1;
    pv     = 1'b0;
    pm     = 0;
  endtask

  task automatic set_idle();
    for (int n = 0; n < 2; n++) begin
      s_rd[n] = 1'b0; s_wr[n] = 1'b0; s_lk[n] = 1'b0;
      s_addr[n] = 16'h0000; s_wd[n] = 16'h0000;
    end
  endtask

  // Apply one cycle of stimulus, check every output against the model, then
  // advance the model to the next cycle.
  task automatic step();
    int win;
    bit req [2];
    bit el [2];
    bit erd, ewr;
    @(negedge clk);
    i_reset     = s_rst;
    i_m0_rd     = s_rd[0];  i_m1_rd     = s_rd[1];
    i_m0_wr     = s_wr[0];  i_m1_wr     = s_wr[1];
    i_m0_lock   = s_lk[0];  i_m1_lock   = s_lk[1];
    i_m0_addr   = s_addr[0]; i_m1_addr  = s_addr[1];
    i_m0_wrdata = s_wd[0];  i_m1_wrdata = s_wd[1];
    #1;
    s_acc[0] = 1'b0;
    s_acc[1] = 1'b0;
    if (s_rst) begin
      chk("rst_wait0", o_m0_waitrequest, 1'b1);
      chk("rst_wait1", o_m1_waitrequest, 1'b1);
      chk("rst_mem_rd", o_mem_rd, 1'b0);
      chk("rst_mem_wr", o_mem_wr, 1'b0);
      chk("rst_rdvalid0", o_m0_rdvalid, 1'b0);
      chk("rst_rdvalid1", o_m1_rdvalid, 1'b0);
      model_reset();
      return;
    end
    for (int n = 0; n < 2; n++) begin
      req[n] = s_rd[n] || s_wr[n];
      el[n]  = req[n] && (owner < 0 || owner == n);
    end
    if (el[0] && el[1]) win = 1 - last_m;
    else if (el[0])     win = 0;
    else if (el[1])     win = 1;
    else                win = -1;
    ewr = (win >= 0) && s_wr[win];
    erd = (win >= 0) && s_rd[win] && !s_wr[win];

    chk("wait0", o_m0_waitrequest, req[0] && win != 0);
    chk("wait1", o_m1_waitrequest, req[1] && win != 1);
    chk("mem_rd", o_mem_rd, erd);
    chk("mem_wr", o_mem_wr, ewr);
    if (erd || ewr) chk("mem_addr", o_mem_addr, s_addr[win]);
    if (ewr) chk("mem_wrdata", o_mem_wrdata, s_wd[win]);
    chk("rdvalid0", o_m0_rdvalid, pv && pm == 0);
    chk("rdvalid1", o_m1_rdvalid, pv && pm == 1);
    if (pv && pm == 0) chk("rddata0", o_m0_rddata, pd);
    if (pv && pm == 1) chk("rddata1", o_m1_rddata, pd);

    pv = erd;
    if (erd) begin
      pm = win;
      pd = ref_mem[s_addr[win][15:1]];
    end
    if (ewr) ref_mem[s_addr[win][15:1]] = s_wd[win];
    if (win >= 0) begin
      last_m     = win;
      s_acc[win] = 1'b1;
    end
`ifdef MEM_ARB_LOCK_EN
    if (owner >= 0) begin
      if (!s_lk[owner]) owner = -1;
    end else if (win >= 0 && s_lk[win]) begin
      owner = win;
    end
`endif
  endtask

  bit held [2];

  initial begin
    i_reset = 1'b1;
    i_m0_rd = 1'b0; i_m0_wr = 1'b0; i_m0_lock = 1'b0; i_m0_addr = 16'h0000; i_m0_wrdata = 16'h0000;
    i_m1_rd = 1'b0; i_m1_wr = 1'b0; i_m1_lock = 1'b0; i_m1_addr = 16'h0000; i_m1_wrdata = 16'h0000;
    for (int i = 0; i < 32768; i++) ref_mem[i] = 16'(i * 7 + 3);
    ref_mem[8] = 16'h1234;
    model_reset();
    set_idle();

    s_rst = 1'b1; step(); step();
    s_rst = 1'b0; step();

    // Single M0 read of 0x0010 returns mem[8] next cycle to M0 only.
    s_rd[0] = 1'b1; s_addr[0] = 16'h0010; step();
    chk("r24_mem_rd", o_mem_rd, 1'b1);
    chk("r24_mem_addr", o_mem_addr, 16'h0010);
    set_idle(); step();
    chk("r24_rdvalid0", o_m0_rdvalid, 1'b1);
    chk("r24_rddata0", o_m0_rddata, 16'h1234);
    chk("r24_rdvalid1", o_m1_rdvalid, 1'b0);

    // Continuous reads from both masters alternate starting with M0.
    s_rst = 1'b1; step(); s_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_rd[0] = 1'b1; s_addr[0] = 16'h0040;
      s_rd[1] = 1'b1; s_addr[1] = 16'h0080;
      step();
      chk("r25_wait0", o_m0_waitrequest, (k % 2) == 1);
      chk("r25_wait1", o_m1_waitrequest, (k % 2) == 0);
    end
    set_idle(); step();

    // M1 write alone goes straight through.
    s_wr[1] = 1'b1; s_addr[1] = 16'h1000; s_wd[1] = 16'h00AB; step();
    chk("r26_mem_wr", o_mem_wr, 1'b1);
    chk("r26_mem_addr", o_mem_addr, 16'h1000);
    chk("r26_mem_wrdata", o_mem_wrdata, 16'h00AB);
    chk("r26_wait1", o_m1_waitrequest, 1'b0);
    set_idle();

    // Read+write together becomes a write only, no read return.
    s_rd[0] = 1'b1; s_wr[0] = 1'b1; s_addr[0] = 16'h0020; s_wd[0] = 16'h5555; step();
    chk("r27_mem_wr", o_mem_wr, 1'b1);
    chk("r27_mem_rd", o_mem_rd, 1'b0);
    set_idle(); step();
    chk("r27_rdvalid0", o_m0_rdvalid, 1'b0);

    // Read back the earlier M1 write through M0.
    s_rd[0] = 1'b1; s_addr[0] = 16'h1000; step();
    set_idle(); step();
    chk("rb_rddata0", o_m0_rddata, 16'h00AB);

    // Reset right after an M1 read grant drops that read.
    s_rd[1] = 1'b1; s_addr[1] = 16'h0030; step();
    chk("r28_mem_rd", o_mem_rd, 1'b1);
    set_idle(); s_rst = 1'b1; step();
    chk("r28_rdvalid1_rst", o_m1_rdvalid, 1'b0);
    s_rst = 1'b0; step();
    chk("r28_rdvalid1_after", o_m1_rdvalid, 1'b0);
    s_rd[0] = 1'b1; s_addr[0] = 16'h0002; s_rd[1] = 1'b1; s_addr[1] = 16'h0004; step();
    chk("r28_wait0", o_m0_waitrequest, 1'b0);
    chk("r28_wait1", o_m1_waitrequest, 1'b1);
    set_idle(); step(); step();

`ifdef MEM_ARB_LOCK_EN
    // M0 locks for 3 read cycles plus 2 idle cycles; M1 waits throughout.
    s_rst = 1'b1; step(); s_rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      s_rd[1] = 1'b1; s_addr[1] = 16'h0050;
      s_rd[0] = (k < 3); s_addr[0] = 16'h0060;
      s_lk[0] = (k < 5);
      step();
      if (k < 5) chk("r29_wait1_locked", o_m1_waitrequest, 1'b1);
      if (k == 6) begin
        chk("r29_wait1_release", o_m1_waitrequest, 1'b0);
        chk("r29_mem_addr", o_mem_addr, 16'h0050);
      end
    end
    set_idle(); step();
`endif

    // Randomized traffic; requests are held until accepted.
    held[0] = 1'b0;
    held[1] = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      int r;
      s_rst = ($urandom_range(0, 249) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!held[n]) begin
          r = $urandom_range(0, 7);
          s_rd[n]   = (r == 3 || r == 4 || r == 7);
          s_wr[n]   = (r == 5 || r == 6 || r == 7);
          s_addr[n] = 16'($urandom_range(0, 31)) << 1;
          s_wd[n]   = 16'($urandom);
        end
        s_lk[n] = ($urandom_range(0, 2) == 0);
      end
      step();
      for (int n = 0; n < 2; n++) held[n] = !s_rst && (s_rd[n] || s_wr[n]) && !s_acc[n];
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
